// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Purpose  : Parameterised UART transmitter (5..9 data bits, optional parity,
//            1 or 2 stop bits) with a global enable that freezes all timing.
// Revision : 1.0
// ============================================================================
module uart_tx_cfg #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_in,
    output logic             d_ready,
    output logic             tx_data,
    output logic             tr_bz,
    output logic             tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam logic [BAUD_W-1:0] c_BAUD_MAX   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_LAST_BIT   = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0]  c_LAST_STOP  = BIT_W'(STOP_BITS - 1);
    localparam logic              c_HAS_PARITY = (PARITY_MODE != 0);
    localparam logic              c_ODD        = (PARITY_MODE == 2);

    logic [2:0]        r_state_q,  w_state_d;
    logic [BAUD_W-1:0] r_baud_q,   w_baud_d;
    logic [BIT_W-1:0]  r_bit_q,    w_bit_d;
    logic [WIDTH-1:0]  r_shift_q,  w_shift_d;
    logic              r_parity_q, w_parity_d;
    logic              r_tx_q,     w_tx_d;
    logic              r_bz_q,     w_bz_d;
    logic              r_done_q,   w_done_d;
    logic              w_accept;

    assign d_ready  = (r_state_q == c_IDLE) && en && !rst;
    assign w_accept = d_ready && d_valid;

    always_comb begin
        w_state_d  = r_state_q;
        w_baud_d   = r_baud_q;
        w_bit_d    = r_bit_q;
        w_shift_d  = r_shift_q;
        w_parity_d = r_parity_q;
        w_tx_d     = r_tx_q;
        w_done_d   = 1'b0;
        if (en) begin
            if (r_state_q == c_IDLE) begin
                w_tx_d = 1'b1;
                if (w_accept) begin
                    w_state_d  = c_START;
                    w_tx_d     = 1'b0;
                    w_baud_d   = c_BAUD_MAX;
                    w_bit_d    = '0;
                    w_shift_d  = d_in;
                    w_parity_d = (^d_in) ^ c_ODD;
                end
            end else if (r_baud_q != '0) begin
                w_baud_d = r_baud_q - 1'b1;
            end else begin
                // Bit boundary: reload the baud counter and present the next bit.
                w_baud_d = c_BAUD_MAX;
                case (r_state_q)
                    c_START: begin
                        w_state_d = c_DATA;
                        w_tx_d    = r_shift_q[0];
                        w_shift_d = r_shift_q >> 1;
                        w_bit_d   = '0;
                    end
                    c_DATA: begin
                        if (r_bit_q == c_LAST_BIT) begin
                            w_bit_d = '0;
                            if (c_HAS_PARITY) begin
                                w_state_d = c_PARITY;
                                w_tx_d    = r_parity_q;
                            end else begin
                                w_state_d = c_STOP;
                                w_tx_d    = 1'b1;
                            end
                        end else begin
                            w_tx_d    = r_shift_q[0];
                            w_shift_d = r_shift_q >> 1;
                            w_bit_d   = r_bit_q + 1'b1;
                        end
                    end
                    c_PARITY: begin
                        w_state_d = c_STOP;
                        w_tx_d    = 1'b1;
                        w_bit_d   = '0;
                    end
                    c_STOP: begin
                        w_tx_d = 1'b1;
                        if (r_bit_q == c_LAST_STOP) begin
                            w_state_d = c_IDLE;
                            w_bit_d   = '0;
                            w_done_d  = 1'b1;
                        end else begin
                            w_bit_d = r_bit_q + 1'b1;
                        end
                    end
                    default: begin
                        w_state_d = c_IDLE;
                        w_tx_d    = 1'b1;
                    end
                endcase
            end
        end
        w_bz_d = (w_state_d != c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= c_IDLE;
            r_baud_q   <= '0;
            r_bit_q    <= '0;
            r_shift_q  <= '0;
            r_parity_q <= 1'b0;
            r_tx_q     <= 1'b1;
            r_bz_q     <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_baud_q   <= w_baud_d;
            r_bit_q    <= w_bit_d;
            r_shift_q  <= w_shift_d;
            r_parity_q <= w_parity_d;
            r_tx_q     <= w_tx_d;
            r_bz_q     <= w_bz_d;
            r_done_q   <= w_done_d;
        end
    end

    assign tx_data = r_tx_q;
    assign tr_bz   = r_bz_q;
    assign tx_done = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_cfg
// Purpose  : Directed self-checking bench for uart_tx_cfg in four configurations.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       dv_a = 1'b0, dv_b = 1'b0, dv_c = 1'b0, dv_d = 1'b0;
    logic [7:0] din  = 8'h00;
    logic [4:0] din5 = 5'h00;
    logic       rdy_a, tx_a, bz_a, done_a;
    logic       rdy_b, tx_b, bz_b, done_b;
    logic       rdy_c, tx_c, bz_c, done_c;
    logic       rdy_d, tx_d, bz_d, done_d;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    // A: 8N1, B: 8E1, C: 8O1, D: 5N2; all at 4 clocks per bit
    uart_tx_cfg #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .d_valid(dv_a), .d_in(din),
        .d_ready(rdy_a), .tx_data(tx_a), .tr_bz(bz_a), .tx_done(done_a));
    uart_tx_cfg #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .d_valid(dv_b), .d_in(din),
        .d_ready(rdy_b), .tx_data(tx_b), .tr_bz(bz_b), .tx_done(done_b));
    uart_tx_cfg #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .d_valid(dv_c), .d_in(din),
        .d_ready(rdy_c), .tx_data(tx_c), .tr_bz(bz_c), .tx_done(done_c));
    uart_tx_cfg #(.WIDTH(5), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2)) u_d (
        .clk(clk), .rst(rst), .en(en), .d_valid(dv_d), .d_in(din5),
        .d_ready(rdy_d), .tx_data(tx_d), .tr_bz(bz_d), .tx_done(done_d));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b1;
        tick;
        tick;
        n_checks++;
        if ({tx_a, tx_b, tx_c, tx_d} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_tx got %b expected 1111", {tx_a, tx_b, tx_c, tx_d});
        end
        n_checks++;
        if ({bz_a, bz_b, bz_c, bz_d, done_a, done_b, done_c, done_d} !== 8'h00) begin
            n_fail++; $display("FAIL reset_bz_done got %b expected 00000000",
                               {bz_a, bz_b, bz_c, bz_d, done_a, done_b, done_c, done_d});
        end
        n_checks++;
        if ({rdy_a, rdy_b, rdy_c, rdy_d} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_rdy_in_rst got %b expected 0000", {rdy_a, rdy_b, rdy_c, rdy_d});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rdy_a, rdy_b, rdy_c, rdy_d} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_rdy_after got %b expected 1111", {rdy_a, rdy_b, rdy_c, rdy_d});
        end
        tick;
    endtask

    task automatic test_8n1;
        logic [9:0] pat = 10'b1101001010;
        int dones = 0;
        din  = 8'hA5;
        dv_a = 1'b1;
        tick;
        dv_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if (tx_a !== pat[i/4]) begin
                n_fail++; $display("FAIL 8n1_tx cycle %0d got %b expected %b", i, tx_a, pat[i/4]);
            end
            n_checks++;
            if (bz_a !== 1'b1 || rdy_a !== 1'b0) begin
                n_fail++; $display("FAIL 8n1_bz_rdy cycle %0d got bz=%b rdy=%b expected bz=1 rdy=0", i, bz_a, rdy_a);
            end
            if (done_a) dones++;
            tick;
        end
        n_checks++;
        if (done_a !== 1'b1 || bz_a !== 1'b0 || tx_a !== 1'b1) begin
            n_fail++; $display("FAIL 8n1_end got done=%b bz=%b tx=%b expected 1 0 1", done_a, bz_a, tx_a);
        end
        if (done_a) dones++;
        tick;
        if (done_a) dones++;
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL 8n1_done_count got %0d expected 1", dones);
        end
    endtask

    task automatic test_parity;
        logic [10:0] pat_even = 11'b11000001110;
        logic [10:0] pat_odd  = 11'b10000001110;
        din  = 8'h07;
        dv_b = 1'b1;
        dv_c = 1'b1;
        tick;
        dv_b = 1'b0;
        dv_c = 1'b0;
        for (int i = 0; i < 44; i++) begin
            n_checks++;
            if (tx_b !== pat_even[i/4] || bz_b !== 1'b1 || done_b !== 1'b0) begin
                n_fail++; $display("FAIL parity_even cycle %0d got tx=%b bz=%b done=%b expected tx=%b bz=1 done=0",
                                   i, tx_b, bz_b, done_b, pat_even[i/4]);
            end
            n_checks++;
            if (tx_c !== pat_odd[i/4] || bz_c !== 1'b1 || done_c !== 1'b0) begin
                n_fail++; $display("FAIL parity_odd cycle %0d got tx=%b bz=%b done=%b expected tx=%b bz=1 done=0",
                                   i, tx_c, bz_c, done_c, pat_odd[i/4]);
            end
            tick;
        end
        n_checks++;
        if ({done_b, bz_b, tx_b, done_c, bz_c, tx_c} !== 6'b101101) begin
            n_fail++; $display("FAIL parity_end got %b expected 101101", {done_b, bz_b, tx_b, done_c, bz_c, tx_c});
        end
        tick;
    endtask

    task automatic test_two_stop;
        logic [7:0] pat = 8'b11111110;
        din5 = 5'h1F;
        dv_d = 1'b1;
        tick;
        dv_d = 1'b0;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (tx_d !== pat[i/4] || bz_d !== 1'b1 || rdy_d !== 1'b0 || done_d !== 1'b0) begin
                n_fail++; $display("FAIL two_stop cycle %0d got tx=%b bz=%b rdy=%b done=%b expected %b 1 0 0",
                                   i, tx_d, bz_d, rdy_d, done_d, pat[i/4]);
            end
            tick;
        end
        n_checks++;
        if ({done_d, bz_d, tx_d, rdy_d} !== 4'b1011) begin
            n_fail++; $display("FAIL two_stop_end got done,bz,tx,rdy=%b expected 1011", {done_d, bz_d, tx_d, rdy_d});
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [9:0] p1 = {1'b1, 8'h55, 1'b0};
        logic [9:0] p2 = {1'b1, 8'hAA, 1'b0};
        logic exp_tx, exp_bz;
        int rdys = 0, idles = 0, dones = 0;
        din  = 8'h55;
        dv_a = 1'b1;
        tick;
        din  = 8'hAA;
        for (int i = 0; i <= 81; i++) begin
            if (i < 40)       begin exp_tx = p1[i/4];      exp_bz = 1'b1; end
            else if (i == 40) begin exp_tx = 1'b1;         exp_bz = 1'b0; end
            else if (i < 81)  begin exp_tx = p2[(i-41)/4]; exp_bz = 1'b1; end
            else              begin exp_tx = 1'b1;         exp_bz = 1'b0; end
            n_checks++;
            if (tx_a !== exp_tx || bz_a !== exp_bz) begin
                n_fail++; $display("FAIL b2b cycle %0d got tx=%b bz=%b expected tx=%b bz=%b",
                                   i, tx_a, bz_a, exp_tx, exp_bz);
            end
            if (i <= 80 && rdy_a === 1'b1) rdys++;
            if (i <= 80 && bz_a === 1'b0) idles++;
            if (done_a === 1'b1) dones++;
            if (i == 41) dv_a = 1'b0;
            if (i < 81) tick;
        end
        n_checks++;
        if (rdys != 1 || idles != 1 || dones != 2) begin
            n_fail++; $display("FAIL b2b_counts got rdy=%0d idle=%0d done=%0d expected 1 1 2", rdys, idles, dones);
        end
        tick;
    endtask

    task automatic test_enable_freeze;
        logic [9:0] pat = 10'b1101001010;
        int k = 0;
        din  = 8'hA5;
        dv_a = 1'b1;
        tick;
        dv_a = 1'b0;
        for (int c = 1; c <= 47; c++) begin
            en = (c >= 18 && c <= 24) ? 1'b0 : 1'b1;
            tick;
            if (en) k++;
            n_checks++;
            if (k < 40) begin
                if (tx_a !== pat[k/4] || bz_a !== 1'b1 || done_a !== 1'b0) begin
                    n_fail++; $display("FAIL freeze cycle %0d got tx=%b bz=%b done=%b expected tx=%b bz=1 done=0",
                                       c, tx_a, bz_a, done_a, pat[k/4]);
                end
            end else if (done_a !== 1'b1 || bz_a !== 1'b0 || tx_a !== 1'b1) begin
                n_fail++; $display("FAIL freeze_end got done=%b bz=%b tx=%b expected 1 0 1", done_a, bz_a, tx_a);
            end
        end
        en   = 1'b0;
        dv_a = 1'b1;
        #1;
        n_checks++;
        if (rdy_a !== 1'b0) begin
            n_fail++; $display("FAIL disabled_rdy got %b expected 0", rdy_a);
        end
        tick;
        tick;
        tick;
        n_checks++;
        if (bz_a !== 1'b0 || tx_a !== 1'b1 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL disabled_no_accept got bz=%b tx=%b done=%b expected 0 1 0", bz_a, tx_a, done_a);
        end
        dv_a = 1'b0;
        en   = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] pat_old = 11'b11000001110;
        logic [10:0] pat_new = 11'b10001111000;
        int dones = 0;
        din  = 8'h07;
        dv_b = 1'b1;
        tick;
        dv_b = 1'b0;
        for (int i = 0; i < 37; i++) begin
            if (done_b === 1'b1) dones++;
            tick;
        end
        n_checks++;
        if (tx_b !== pat_old[9] || bz_b !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_parity got tx=%b bz=%b expected 1 1", tx_b, bz_b);
        end
        rst = 1'b1;
        tick;
        n_checks++;
        if (tx_b !== 1'b1 || bz_b !== 1'b0 || done_b !== 1'b0 || rdy_b !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_edge got tx=%b bz=%b done=%b rdy=%b expected 1 0 0 0",
                               tx_b, bz_b, done_b, rdy_b);
        end
        rst  = 1'b0;
        din  = 8'h3C;
        dv_b = 1'b1;
        #1;
        n_checks++;
        if (rdy_b !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_rdy got %b expected 1", rdy_b);
        end
        tick;
        dv_b = 1'b0;
        for (int i = 0; i < 44; i++) begin
            n_checks++;
            if (tx_b !== pat_new[i/4] || bz_b !== 1'b1) begin
                n_fail++; $display("FAIL rst_new_frame cycle %0d got tx=%b bz=%b expected tx=%b bz=1",
                                   i, tx_b, bz_b, pat_new[i/4]);
            end
            if (done_b === 1'b1) dones++;
            tick;
        end
        n_checks++;
        if (done_b !== 1'b1 || dones != 0) begin
            n_fail++; $display("FAIL rst_done got end=%b earlier=%0d expected 1 0", done_b, dones);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_two_stop;
        test_back_to_back;
        test_enable_freeze;
        test_reset_mid_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2.
- PARITY_MODE, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, sole clock; all logic on its rising edge.
- rst, input, 1, reset; synchronous, active-high.
- en, input, 1, global enable; low freezes the block.
- d_valid, input, 1, source has a word on d_in.
- d_in, input, WIDTH, word to transmit.
- d_ready, output, 1, block can accept a word this cycle.
- tx_data, output, 1, serial line.
- tr_bz, output, 1, frame in progress.
- tx_done, output, 1, one-cycle pulse at frame end.

REQ-003 One clock, clk; reset is synchronous and active-high on rst.

REQ-004 tx_data, tr_bz and tx_done SHALL be driven directly from flops.

Function
REQ-005 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.

REQ-006 d_ready SHALL be asserted exactly when state==IDLE, en=1 and rst=0.

REQ-007 Accept SHALL occur at a rising edge where d_valid=1 and d_ready=1. On accept:
- d_in is latched into an internal shift register.
- Parity is computed from the latched word.
- Next state is START.
- d_in is ignored thereafter until the next accept.

REQ-008 Each serial bit SHALL last exactly CLKS_PER_BIT enabled cycles, timed by a baud counter that reloads at every bit boundary.

REQ-009 Line levels SHALL be:
- START: 0.
- DATA: d_in bits, LSB first, WIDTH bits.
- PARITY: the parity bit.
- STOP: 1, for STOP_BITS bit periods.

REQ-010 With PARITY_MODE=0, the PARITY state SHALL be skipped (DATA goes directly to STOP).

REQ-011 Parity bit SHALL be the XOR of the data bits for even mode, and its inverse for odd mode.

REQ-012 tx_data SHALL go low on the edge following accept. The total frame SHALL be (1 + WIDTH + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT cycles.

REQ-013 When the last stop bit completes:
- Next state is IDLE.
- tx_done is 1 for exactly one cycle.
- tx_data remains 1.

REQ-014 tr_bz SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.

REQ-015 Back-to-back: a word offered continuously SHALL be accepted in the IDLE cycle following tx_done, giving exactly one idle-high cycle between frames.

REQ-016 When en=0:
- The state, baud counter, bit counter and shift register hold.
- tx_data holds its current level.
- d_ready is 0 and no accept occurs.
- tx_done does not pulse.
On en returning to 1, timing SHALL resume from where it stopped.

REQ-017 In IDLE, tx_data SHALL be 1.

REQ-018 The bit counter SHALL be wide enough for WIDTH-1. The baud counter SHALL be clog2(CLKS_PER_BIT) bits wide. Neither counter shall wrap mid-bit.

Reset
REQ-019 When rst=1 at a rising edge, the following SHALL apply on that edge, regardless of en:
- State goes to IDLE.
- tx_data=1, tr_bz=0, tx_done=0.
- Baud and bit counters are cleared.

REQ-020 Reset asserted mid-frame SHALL abort the frame. The line goes high on the reset edge, and the discarded word is not retransmitted.

REQ-021 d_ready SHALL be 0 while rst=1, and SHALL be 1 in the first cycle after reset release if en=1.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- 8N1, CLKS_PER_BIT=4, accept 0xA5 -> tx_data pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tr_bz high for 40 cycles; tx_done pulses once.
- PARITY_MODE=1, send 0x07 -> parity bit 1. PARITY_MODE=2, send 0x07 -> parity bit 0. Frame is 11 bits in both cases.
- STOP_BITS=2, WIDTH=5, send 0x1F -> line pattern 0,1,1,1,1,1,1,1; d_ready stays 0 until the second stop bit ends.
- d_valid held high with 0x55 then 0xAA -> two frames separated by exactly 1 idle cycle; d_ready pulses once per frame.
- en dropped for 7 cycles in the middle of data bit 3 -> tx_data and tr_bz frozen; bit 3 still lasts 4 enabled cycles; frame otherwise unchanged.
- rst pulsed during the parity bit -> tx_data=1, tr_bz=0 on the reset edge; no tx_done; a new frame is accepted the cycle after rst deasserts.
